// File: rtl/gray_ptr_sync_decoder.sv
// Purpose: re-time a source-domain gray pointer into clk, decode it to binary, report per-cycle advance.
// Latency: 3 clk edges from gray_in sampling to bin_out/delta; bin_valid rises on the 3rd edge after reset.
// Backpressure: none; outputs update every edge. Optional GRAY_STEP_CHECK_EN adds sticky step_err detection.
module gray_ptr_sync_decoder #(
    parameter int ADDR_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] gray_in,
    output logic [ADDR_LEN-1:0] bin_out,
    output logic                bin_valid,
    output logic [ADDR_LEN-1:0] delta,
    output logic                step_err
);

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [ADDR_LEN-1:0] g2b(input logic [ADDR_LEN-1:0] g);
        logic [ADDR_LEN-1:0] b;
        b = '0;
        b[ADDR_LEN-1] = g[ADDR_LEN-1];
        for (int i = ADDR_LEN - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // sync1 may be metastable; only sync2 onward feeds any logic.
    logic [ADDR_LEN-1:0] sync1;
    logic [ADDR_LEN-1:0] sync2;
    logic [ADDR_LEN-1:0] sync_bin;
    logic [1:0]          fill_cnt;

    // Decode the second synchronizer stage.
    always_comb begin
        sync_bin = g2b(sync2);
    end

    // Synchronizer, decode register and modulo delta; fill counter saturates at 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            bin_out  <= '0;
            delta    <= '0;
            fill_cnt <= 2'd0;
        end else begin
            sync1    <= gray_in;
            sync2    <= sync1;
            bin_out  <= sync_bin;
            delta    <= sync_bin - bin_out;
            if (fill_cnt != 2'd3) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
        end
    end

    assign bin_valid = (fill_cnt == 2'd3);

`ifdef GRAY_STEP_CHECK_EN
    logic [ADDR_LEN-1:0] sync3;
    logic                multi_bit;

    // A legal gray step changes at most one bit between consecutive synced samples.
    always_comb begin
        multi_bit = ($countones(sync2 ^ sync3) > 1);
    end

    // Keep previous synced sample; latch any illegal step once the pipeline is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync3    <= '0;
            step_err <= 1'b0;
        end else begin
            sync3 <= sync2;
            if (multi_bit && bin_valid) begin
                step_err <= 1'b1;
            end
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
module tb_gray_ptr_sync_decoder;
    localparam int N    = 4;
    localparam int SPAN = 1 << N;

    logic         clk;
    logic         reset;
    logic [N-1:0] gray_in;
    logic [N-1:0] bin_out;
    logic         bin_valid;
    logic [N-1:0] delta;
    logic         step_err;

    int tests_run;
    int tests_failed;

    // Reference model state: every gray sample taken since the last reset edge.
    int hist[$];
    int exp_bin;
    int exp_prev;
    int exp_delta;
    int exp_valid;
    int exp_err;

    gray_ptr_sync_decoder #(.ADDR_LEN(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .delta     (delta),
        .step_err  (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Binary value whose gray code equals g, found by search.
    function automatic int decode(input int g);
        for (int v = 0; v < SPAN; v++) begin
            if (((v ^ (v >> 1)) & (SPAN - 1)) == g) return v;
        end
        return -1;
    endfunction

    function automatic int encode(input int b);
        return (b ^ (b >> 1)) & (SPAN - 1);
    endfunction

    // Sample j (1-based, counted from reset release); before the first sample the pipe holds zeros.
    function automatic int samp(input int j);
        if (j < 1) return 0;
        return hist[j-1];
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, compare all outputs #1 after the edge.
    task automatic tick(input logic rst, input int g, input string tag);
        int k;
        reset   = rst;
        gray_in = g[N-1:0];
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            exp_bin   = 0;
            exp_prev  = 0;
            exp_delta = 0;
            exp_valid = 0;
            exp_err   = 0;
        end else begin
            hist.push_back(g & (SPAN - 1));
            k = hist.size();
            exp_bin   = decode(samp(k - 2));
            exp_delta = (exp_bin - exp_prev + SPAN) % SPAN;
            exp_valid = (k >= 3) ? 1 : 0;
`ifdef GRAY_STEP_CHECK_EN
            if ((k - 1) >= 3 && $countones(samp(k - 2) ^ samp(k - 3)) > 1) exp_err = 1;
`endif
            exp_prev = exp_bin;
        end
        check({tag, ".bin_out"},   int'(bin_out),   exp_bin);
        check({tag, ".delta"},     int'(delta),     exp_delta);
        check({tag, ".bin_valid"}, int'(bin_valid), exp_valid);
        check({tag, ".step_err"},  int'(step_err),  exp_err);
    endtask

    initial begin
        int g;
        tests_run    = 0;
        tests_failed = 0;
        exp_bin = 0; exp_prev = 0; exp_delta = 0; exp_valid = 0; exp_err = 0;
        reset   = 1'b1;
        gray_in = '0;

        // Reset held with a nonzero gray input: everything stays zero.
        tick(1'b1, 4'b1010, "rst_hold");
        tick(1'b1, 4'b1010, "rst_hold");

        // Fill: gray 0110 (bin 4) appears with bin_valid on the 3rd edge, then holds with delta 0.
        for (int i = 0; i < 6; i++) tick(1'b0, 4'b0110, "fill");
        check("fill.direct_bin", int'(bin_out), 4);
        check("fill.direct_delta", int'(delta), 0);

        // Walk one gray code per cycle 0..15 and wrap to 0; flush with held 0.
        for (int b = 0; b <= SPAN; b++) tick(1'b0, encode(b % SPAN), "walk");
        for (int i = 0; i < 3; i++) tick(1'b0, 0, "walk_flush");

        // Two-bit jump 0000 -> 0011 (bin 2) after valid.
        tick(1'b1, 0, "jump_rst");
        for (int i = 0; i < 4; i++) tick(1'b0, 4'b0000, "jump_pre");
        for (int i = 0; i < 5; i++) tick(1'b0, 4'b0011, "jump");
        check("jump.direct_bin", int'(bin_out), 2);

        // One-bit change 0000 -> 0010 (bin 3).
        tick(1'b1, 0, "one_rst");
        for (int i = 0; i < 4; i++) tick(1'b0, 4'b0000, "one_pre");
        for (int i = 0; i < 5; i++) tick(1'b0, 4'b0010, "one");
        check("one.direct_bin", int'(bin_out), 3);
        check("one.direct_err", int'(step_err), 0);

        // Reset mid-operation while bin 9 (gray 1101) is held, then refill.
        for (int i = 0; i < 5; i++) tick(1'b0, 4'b1101, "mid_pre");
        tick(1'b1, 4'b1101, "mid_rst");
        for (int i = 0; i < 4; i++) tick(1'b0, 4'b1101, "mid_refill");
        check("mid.direct_bin", int'(bin_out), 9);

        // Random: mostly single gray steps, some multi-step jumps, holds and rare resets.
        g = 0;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                tick(1'b1, $urandom_range(0, SPAN - 1), "rnd_rst");
            end else begin
                if (r < 55)      g = encode((decode(g) + 1) % SPAN);
                else if (r < 75) g = encode((decode(g) + $urandom_range(2, 5)) % SPAN);
                else if (r < 85) g = $urandom_range(0, SPAN - 1);
                tick(1'b0, g, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
